// File: rtl/mem_sys_pkg.sv
// Shared memory-system constants and width helpers.
package mem_sys_pkg;

  // Width of the conflict counter, also used by the perf-counter block.
  localparam int unsigned CONFLICT_CNT_W = 16;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Number of low address bits that select the bank.
  function automatic int unsigned bank_bits(input int unsigned bank_count);
    return clog2(bank_count);
  endfunction

  // Number of address bits left for the row within a bank.
  function automatic int unsigned row_bits(input int unsigned addr_width,
                                           input int unsigned bank_count);
    return addr_width - clog2(bank_count);
  endfunction

  // Keeps a derived vector width at least one bit.
  function automatic int unsigned nz(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/ram_bank.sv
// Single memory bank: one write/read port, registered read, no reset on storage.
module ram_bank #(
  parameter int unsigned WORDS  = 1024,
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [WORDS];
  logic [DATA_W-1:0] r_rdata;

  // Storage write and registered read.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/banked_shared_ram.sv
// Interleaved multi-bank shared data memory with per-bank round-robin arbitration.
module banked_shared_ram
  import mem_sys_pkg::*;
#(
  parameter int unsigned core_count = 2,
  parameter int unsigned reg_width  = 12,
  parameter int unsigned addr_width = 12,
  parameter int unsigned mem_size   = 4096,
  parameter int unsigned bank_count = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [core_count-1:0]           req,
  input  logic [core_count-1:0]           mem_write,
  input  logic [addr_width*core_count-1:0] address,
  input  logic [reg_width*core_count-1:0] datain,
  output logic [core_count-1:0]           grant,
  output logic [core_count-1:0]           rvalid,
  output logic [reg_width*core_count-1:0] dataout,
  output logic [CONFLICT_CNT_W-1:0]       conflict_cycles
);

  localparam int unsigned BANK_BITS = bank_bits(bank_count);
  localparam int unsigned BIDX_W    = nz(BANK_BITS);
  localparam int unsigned WORDS     = mem_size / bank_count;
  localparam int unsigned BA_W      = nz(clog2(WORDS));
  localparam int unsigned PORT_W    = nz(clog2(core_count));

  // Per-port decoded request fields
  logic [addr_width-1:0] w_addr    [core_count];
  logic [reg_width-1:0]  w_wdata   [core_count];
  logic [BIDX_W-1:0]     w_bank_of [core_count];
  logic [BA_W-1:0]       w_row     [core_count];
  logic                  w_oor     [core_count];

  // Per-bank arbitration results
  logic                  w_bank_en    [bank_count];
  logic [PORT_W-1:0]     w_bank_port  [bank_count];
  logic [PORT_W-1:0]     w_rr_nxt     [bank_count];
  logic                  w_bank_we    [bank_count];
  logic                  w_bank_re    [bank_count];
  logic [reg_width-1:0]  w_bank_rdata [bank_count];

  logic [PORT_W-1:0]     r_rr [bank_count];

  // Response routing state: which bank answers each port next cycle
  logic [core_count-1:0] r_rvalid;
  logic [BIDX_W-1:0]     r_src    [core_count];
  logic                  r_oor    [core_count];
  logic [reg_width-1:0]  r_hold   [core_count];
  logic [core_count-1:0] w_rv_nxt;
  logic [BIDX_W-1:0]     w_src_nxt [core_count];
  logic                  w_oor_nxt [core_count];
  logic [reg_width-1:0]  w_rd_data [core_count];

  logic [CONFLICT_CNT_W-1:0] r_conflict;
  logic                      w_conflict;

  for (genvar gp = 0; gp < core_count; gp++) begin : g_port
    assign w_addr[gp]  = address[gp*addr_width +: addr_width];
    assign w_wdata[gp] = datain[gp*reg_width +: reg_width];
    assign w_oor[gp]   = ({1'b0, w_addr[gp]} >= (addr_width + 1)'(mem_size));
    if (BANK_BITS > 0) begin : g_bidx
      assign w_bank_of[gp] = w_addr[gp][BANK_BITS-1:0];
    end else begin : g_nobidx
      assign w_bank_of[gp] = '0;
    end
    assign w_row[gp]     = w_addr[gp][BANK_BITS +: BA_W];
    assign w_rd_data[gp] = r_oor[gp] ? '0 : w_bank_rdata[r_src[gp]];
    assign rvalid[gp]    = r_rvalid[gp];
    assign dataout[gp*reg_width +: reg_width] = r_rvalid[gp] ? w_rd_data[gp] : r_hold[gp];
  end

  // Per-bank round-robin pick: first requesting port at or after rr[b], with wrap.
  always_comb begin
    grant = '0;
    for (int unsigned b = 0; b < bank_count; b++) begin
      w_bank_en[b]   = 1'b0;
      w_bank_port[b] = '0;
      w_rr_nxt[b]    = r_rr[b];
      for (int unsigned k = 0; k < core_count; k++) begin
        int unsigned idx;
        idx = (32'(r_rr[b]) + k) % core_count;
        if (!w_bank_en[b] && !reset && req[PORT_W'(idx)] &&
            (w_bank_of[PORT_W'(idx)] == BIDX_W'(b))) begin
          w_bank_en[b]   = 1'b1;
          w_bank_port[b] = PORT_W'(idx);
          w_rr_nxt[b]    = PORT_W'((idx + 1) % core_count);
        end
      end
      if (w_bank_en[b]) grant[w_bank_port[b]] = 1'b1;
    end
  end

  for (genvar gb = 0; gb < bank_count; gb++) begin : g_bank
    // Out-of-range accesses are granted but never touch storage.
    assign w_bank_we[gb] = w_bank_en[gb] & mem_write[w_bank_port[gb]] & ~w_oor[w_bank_port[gb]];
    assign w_bank_re[gb] = w_bank_en[gb] & ~mem_write[w_bank_port[gb]] & ~w_oor[w_bank_port[gb]];

    ram_bank #(
      .WORDS  (WORDS),
      .DATA_W (reg_width),
      .ADDR_W (BA_W)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_bank_we[gb]),
      .i_re    (w_bank_re[gb]),
      .i_addr  (w_row[w_bank_port[gb]]),
      .i_wdata (w_wdata[w_bank_port[gb]]),
      .o_rdata (w_bank_rdata[gb])
    );
  end

  // Route each granted read back to its port for the following cycle.
  always_comb begin
    w_rv_nxt = '0;
    for (int unsigned p = 0; p < core_count; p++) begin
      w_src_nxt[p] = r_src[p];
      w_oor_nxt[p] = r_oor[p];
    end
    for (int unsigned b = 0; b < bank_count; b++) begin
      if (w_bank_en[b] && !mem_write[w_bank_port[b]]) begin
        w_rv_nxt[w_bank_port[b]]  = 1'b1;
        w_src_nxt[w_bank_port[b]] = BIDX_W'(b);
        w_oor_nxt[w_bank_port[b]] = w_oor[w_bank_port[b]];
      end
    end
  end

  assign w_conflict      = |(req & ~grant);
  assign conflict_cycles = r_conflict;

  // Pointers, response routing, held read data and saturating conflict counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned b = 0; b < bank_count; b++) r_rr[b] <= '0;
      for (int unsigned p = 0; p < core_count; p++) begin
        r_src[p]  <= '0;
        r_oor[p]  <= 1'b0;
        r_hold[p] <= '0;
      end
      r_rvalid   <= '0;
      r_conflict <= '0;
    end else begin
      for (int unsigned b = 0; b < bank_count; b++) r_rr[b] <= w_rr_nxt[b];
      for (int unsigned p = 0; p < core_count; p++) begin
        r_src[p] <= w_src_nxt[p];
        r_oor[p] <= w_oor_nxt[p];
        // Capture the word being presented so it persists once rvalid drops.
        if (r_rvalid[p]) r_hold[p] <= w_rd_data[p];
      end
      r_rvalid <= w_rv_nxt;
      if (w_conflict && (r_conflict != '1)) r_conflict <= r_conflict + 1'b1;
    end
  end

endmodule

// File: tb/tb_banked_shared_ram.sv
// Randomized and directed bench for banked_shared_ram against a behavioural model.
module tb_banked_shared_ram;

  localparam int CC = 2;
  localparam int RW = 12;
  localparam int AW = 12;
  localparam int BC = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CC-1:0] req = '0;
  logic [CC-1:0] mem_write = '0;
  logic [AW*CC-1:0] address = '0;
  logic [RW*CC-1:0] datain = '0;
  logic [CC-1:0] grant, rvalid;
  logic [RW*CC-1:0] dataout;
  logic [15:0]   conflict_cycles;
  logic [CC-1:0] s_grant, s_rvalid;
  logic [RW*CC-1:0] s_dataout;
  logic [15:0]   s_conflict_cycles;

  always #5 clk = ~clk;

  banked_shared_ram #(
    .core_count(CC), .reg_width(RW), .addr_width(AW), .mem_size(4096), .bank_count(BC)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .mem_write(mem_write), .address(address),
    .datain(datain), .grant(grant), .rvalid(rvalid), .dataout(dataout),
    .conflict_cycles(conflict_cycles)
  );

  banked_shared_ram #(
    .core_count(CC), .reg_width(RW), .addr_width(AW), .mem_size(2048), .bank_count(BC)
  ) dut_small (
    .clk(clk), .reset(reset), .req(req), .mem_write(mem_write), .address(address),
    .datain(datain), .grant(s_grant), .rvalid(s_rvalid), .dataout(s_dataout),
    .conflict_cycles(s_conflict_cycles)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [RW-1:0] m_mem [4096];
  bit            m_known [4096];
  int            m_rr [BC];
  logic [CC-1:0] m_rv;
  logic [RW-1:0] m_dout [CC];
  bit            m_dk [CC];
  int            m_cc;
  logic [CC-1:0] m_last_g;
  logic [CC-1:0] d_last_g;
  logic [CC-1:0] s_last_g;
  int            g_tally [CC];

  task automatic m_reset();
    for (int b = 0; b < BC; b++) m_rr[b] = 0;
    for (int p = 0; p < CC; p++) begin
      m_dout[p] = '0;
      m_dk[p]   = 1'b1;
    end
    m_rv = '0;
    m_cc = 0;
    m_last_g = '0;
  endtask

  task automatic set_port(input int p, input bit rq, input bit we,
                          input logic [AW-1:0] a, input logic [RW-1:0] d);
    req[p] = rq;
    mem_write[p] = we;
    address[p*AW +: AW] = a;
    datain[p*RW +: RW] = d;
  endtask

  // One clock cycle: check grant mid-cycle, then outputs just after the edge.
  task automatic step();
    logic [CC-1:0] eg;
    logic [CC-1:0] nrv;
    logic [RW-1:0] nd [CC];
    bit            nk [CC];
    int            bw [BC];
    @(negedge clk);
    eg = '0;
    for (int b = 0; b < BC; b++) begin
      int bestd;
      bw[b] = -1;
      bestd = CC;
      for (int p = 0; p < CC; p++) begin
        int a, d;
        a = int'(address[p*AW +: AW]);
        d = (p - m_rr[b] + CC) % CC;
        if (req[p] && (a % BC) == b && d < bestd) begin
          bestd = d;
          bw[b] = p;
        end
      end
      if (bw[b] >= 0) eg[bw[b]] = 1'b1;
    end
    check("grant", 32'(grant), 32'(eg));
    d_last_g = grant;
    s_last_g = s_grant;
    for (int p = 0; p < CC; p++) if (grant[p]) g_tally[p]++;
    for (int p = 0; p < CC; p++) begin
      nrv[p] = 1'b0;
      nd[p]  = m_dout[p];
      nk[p]  = m_dk[p];
      if (eg[p] && !mem_write[p]) begin
        int a;
        a = int'(address[p*AW +: AW]);
        nrv[p] = 1'b1;
        nd[p]  = m_mem[a];
        nk[p]  = m_known[a];
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < CC; p++) begin
      if (eg[p] && mem_write[p]) begin
        int a;
        a = int'(address[p*AW +: AW]);
        m_mem[a]   = datain[p*RW +: RW];
        m_known[a] = 1'b1;
      end
    end
    for (int b = 0; b < BC; b++) if (bw[b] >= 0) m_rr[b] = (bw[b] + 1) % CC;
    if ((req & ~eg) != '0 && m_cc < 65535) m_cc++;
    m_rv = nrv;
    for (int p = 0; p < CC; p++) begin
      if (nrv[p]) begin
        m_dout[p] = nd[p];
        m_dk[p]   = nk[p];
      end
    end
    m_last_g = eg;
    check("rvalid", 32'(rvalid), 32'(m_rv));
    check("conflict", 32'(conflict_cycles), 32'(m_cc));
    for (int p = 0; p < CC; p++)
      if (m_dk[p]) check($sformatf("dout%0d", p), 32'(dataout[p*RW +: RW]), 32'(m_dout[p]));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    mem_write = '0;
    @(posedge clk);
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_dataout", 32'(dataout), 32'h0);
    check("rst_conflict", 32'(conflict_cycles), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) m_known[i] = 1'b0;
    for (int p = 0; p < CC; p++) g_tally[p] = 0;
    m_reset();

    // Parallel access to different banks
    do_reset();
    set_port(0, 1, 1, 12'h004, 12'h0A5);
    set_port(1, 1, 1, 12'h005, 12'h05A);
    step();
    check("par_wr_grant", 32'(d_last_g), 32'h3);
    set_port(0, 1, 0, 12'h004, 12'h000);
    set_port(1, 1, 0, 12'h005, 12'h000);
    step();
    check("par_rd_grant", 32'(d_last_g), 32'h3);
    check("par_rvalid", 32'(rvalid), 32'h3);
    check("par_d0", 32'(dataout[11:0]), 32'h0A5);
    check("par_d1", 32'(dataout[23:12]), 32'h05A);
    check("par_conflict", 32'(conflict_cycles), 32'h0);

    // Same-bank conflict from reset
    do_reset();
    set_port(0, 1, 0, 12'h008, 12'h000);
    set_port(1, 1, 0, 12'h008, 12'h000);
    step();
    check("cf_grant1", 32'(d_last_g), 32'h1);
    check("cf_rvalid1", 32'(rvalid), 32'h1);
    set_port(0, 0, 0, 12'h000, 12'h000);
    step();
    check("cf_grant2", 32'(d_last_g), 32'h2);
    check("cf_rvalid2", 32'(rvalid), 32'h2);
    set_port(1, 0, 0, 12'h000, 12'h000);
    step();
    check("cf_conflict", 32'(conflict_cycles), 32'h1);

    // Fairness on bank 2
    do_reset();
    for (int p = 0; p < CC; p++) g_tally[p] = 0;
    set_port(0, 1, 0, 12'h002, 12'h000);
    set_port(1, 1, 0, 12'h006, 12'h000);
    for (int i = 0; i < 8; i++) begin
      step();
      check("fair_grant", 32'(d_last_g), (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    check("fair_tally0", 32'(g_tally[0]), 32'd4);
    check("fair_tally1", 32'(g_tally[1]), 32'd4);
    check("fair_conflict", 32'(conflict_cycles), 32'd8);

    // Write then read the same address on consecutive cycles
    set_port(0, 0, 0, 12'h000, 12'h000);
    set_port(1, 1, 1, 12'h3FF, 12'hFFF);
    step();
    set_port(1, 1, 0, 12'h3FF, 12'h000);
    step();
    check("wtr_rvalid1", 32'(rvalid[1]), 32'h1);
    check("wtr_d1", 32'(dataout[23:12]), 32'hFFF);

    // Reset in the cycle after a granted read
    set_port(0, 1, 1, 12'h010, 12'h123);
    set_port(1, 0, 0, 12'h000, 12'h000);
    step();
    set_port(0, 1, 0, 12'h010, 12'h000);
    step();
    check("mid_rvalid_pre", 32'(rvalid[0]), 32'h1);
    set_port(0, 1, 1, 12'h010, 12'h777);
    reset = 1'b1;
    #1;
    check("mid_rvalid", 32'(rvalid), 32'h0);
    check("mid_dataout", 32'(dataout), 32'h0);
    check("mid_conflict", 32'(conflict_cycles), 32'h0);
    @(negedge clk);
    check("mid_grant_in_reset", 32'(grant), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    req = '0;
    m_reset();
    @(posedge clk);
    #1;
    set_port(0, 1, 0, 12'h010, 12'h000);
    step();
    check("mid_keep_d0", 32'(dataout[11:0]), 32'h123);

    // Out-of-range access on the 2048-word instance
    do_reset();
    set_port(0, 1, 1, 12'h800, 12'h123);
    set_port(1, 0, 0, 12'h000, 12'h000);
    step();
    check("oor_wr_grant", 32'(s_last_g[0]), 32'h1);
    set_port(0, 1, 0, 12'h800, 12'h000);
    step();
    check("oor_rd_grant", 32'(s_last_g[0]), 32'h1);
    check("oor_rvalid", 32'(s_rvalid[0]), 32'h1);
    check("oor_d0", 32'(s_dataout[11:0]), 32'h000);

    // Randomized traffic; stalled ports hold their request until granted
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < CC; p++) begin
        if (!req[p] || m_last_g[p]) begin
          logic [AW-1:0] a;
          a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
          set_port(p, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, RW'($urandom));
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/banked_shared_ram.md
# banked_shared_ram

Shared data memory for the multicore processor, replacing the fixed dual-port data RAM. It is interleaved across `bank_count` banks. Accesses from different cores to different banks complete in parallel. Accesses to the same bank are serialised by a per-bank round-robin arbiter using a grant/stall handshake. Each core port drives one request per cycle and receives registered read data one cycle after its grant.

## Interface
- `core_count`, 2: number of core ports; ≥1.
- `reg_width`, 12: data word width.
- `addr_width`, 12: word address width per port.
- `mem_size`, 4096: total words; must equal bank_count × words per bank, and be ≤ 2^addr_width.
- `bank_count`, 4: power of two, ≥1, ≤ mem_size.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  core_count  per-port access request.
- `mem_write`  in  core_count  per-port; 1 = write, 0 = read; qualified by req.
- `address`  in  addr_width*core_count  flattened; port p occupies bits [p*addr_width +: addr_width].
- `datain`  in  reg_width*core_count  flattened write data per port.
- `grant`  out  core_count  combinational; the port's access is accepted this cycle.
- `rvalid`  out  core_count  registered; read data for the port is valid this cycle.
- `dataout`  out  reg_width*core_count  flattened registered read data per port.
- `conflict_cycles`  out  16  saturating count of cycles in which at least one req was not granted.

## Operation
- Bank index = address[log2(bank_count)-1:0].
- Row within bank = address[addr_width-1:log2(bank_count)].
- With bank_count = 1, bank index is 0 and the row is the full address.
- Each bank keeps one round-robin pointer rr[b] of width log2(core_count).
  - Among ports with req = 1 targeting bank b, the winner is the first port at or after rr[b], scanning upward with wrap.
- After a grant in bank b, rr[b] ← winner + 1, mod core_count. A bank with no requests keeps its pointer.
- Each bank has at most one grant per cycle, so all banks together grant at most min(core_count, bank_count) ports.
- Granted write: the word is stored at the rising edge ending the grant cycle.
- Granted read: dataout[p] and rvalid[p] update at that same edge.
- Non-granted port: the core stalls and must hold req, mem_write, address and datain stable until granted.
  - The arbiter does not check that these are held; a change is treated as a new request.
- When rvalid[p] = 0, dataout[p] holds its last value.
- A write followed by a read of the same address in the next cycle returns the new data.
- Two ports cannot access one address in the same cycle: they share a bank, so only one is granted.
- An address ≥ mem_size is still granted. The write is dropped, and the read returns 0 with rvalid = 1.
- conflict_cycles increments by 1 on each cycle where req & ~grant ≠ 0, and saturates at 0xFFFF.

## Timing
- grant: same cycle as req; combinational from req, address and rr.
- Read latency: data on dataout[p] with rvalid[p] = 1 exactly 1 cycle after the grant cycle, for 1 cycle unless re-granted.
- Worst-case wait: a continuously requesting port is granted within core_count cycles.
- Reset (asynchronous assert, synchronous release) clears:
  - all rr to 0;
  - rvalid to 0 and dataout to 0;
  - conflict_cycles to 0.
- Reset does not clear memory contents.
- Reset asserted mid-operation: any pending read response is discarded (rvalid stays 0), and no write occurs at an edge while reset is high.
- grant is 0 while reset is high.

## Structure
- Shared package `mem_sys_pkg` holds:
  - a clog2 helper;
  - the bank-index and row-width localparam formulas;
  - the conflict counter width constant (16), shared with the future perf-counter block.
- Sub-module `ram_bank`: one bank with words = mem_size / bank_count, one write/read port, registered read, no reset on the storage array. It is instantiated bank_count times.
- The top level contains the per-bank round-robin pointers, the port-to-bank crossbar, the response routing (grant bank → port, registered) and the counter.

## Test plan
- Parallel access, bank_count = 4, core_count = 2:
  - Stimulus: port0 writes 0x0A5 to addr 0x004 (bank 0) while port1 writes 0x05A to addr 0x005 (bank 1); both read back next cycle.
  - Required: grant = 2'b11 in both cycles; the cycle after the reads, rvalid = 2'b11 with dataout 0x0A5 / 0x05A; conflict_cycles = 0.
- Bank conflict:
  - Stimulus: both ports read addr 0x008 (bank 0), held until granted, starting from reset.
  - Required: grant = 01, then 10; rvalid[0] one cycle after its grant, then rvalid[1]; conflict_cycles = 1.
- Fairness:
  - Stimulus: both ports continuously request bank 2 for 8 cycles.
  - Required: grants alternate 01, 10, …; each port gets 4 grants; conflict_cycles = 8.
- Write-then-read:
  - Stimulus: port1 writes 0xFFF to 0x3FF, then reads 0x3FF in the next cycle.
  - Required: dataout[1] = 0xFFF with rvalid[1] = 1.
- Reset mid-read:
  - Stimulus: assert reset in the cycle after a granted read.
  - Required: rvalid = 0, dataout = 0, conflict_cycles = 0 immediately.
  - Required: a location written before reset is still readable after release.
- Out-of-range address, with mem_size = 2048:
  - Stimulus: write 0x123 to addr 0x800, then read addr 0x800.
  - Required: the read returns 0 with rvalid = 1.
